// File: rtl/cdc_loopback.sv
// Byte-stream loopback endpoint standing in for the USB host: buffers the CPU's
// outgoing bytes and returns them, optionally holding them until a full line is buffered.
module cdc_loopback #(
  parameter int          DEPTH     = 16,
  parameter int          LINE_MODE = 1,
  parameter logic [7:0]  TERM      = 8'h0D
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [7:0]               in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [7:0]               out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              rx_cnt_o,
  output logic [15:0]              tx_cnt_o,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Handshake: a byte moves on a channel in any cycle where valid && ready.
  // Once out_valid_o rises it holds, with stable data, until that transfer.
  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] r_term_cnt;
  logic [15:0]   r_rx_cnt;
  logic [15:0]   r_tx_cnt;
  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_push;
  logic          w_pop;
  logic          w_push_term;
  logic          w_pop_term;
  logic          w_not_empty;
  logic [7:0]    w_head;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_not_empty = (r_level != '0);
  assign in_ready_o  = (r_level != FULL);
  assign out_valid_o = (LINE_MODE == 0) ? w_not_empty
                                        : (w_not_empty && (r_state != S_HOLD));
  assign out_data_o  = out_valid_o ? w_head : 8'h00;
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_push_term = w_push && (in_data_i == TERM);
  assign w_pop_term  = w_pop && (w_head == TERM);

  assign level_o  = r_level;
  assign rx_cnt_o = r_rx_cnt;
  assign tx_cnt_o = r_tx_cnt;
  assign state_o  = r_state;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_term_cnt <= '0;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_state    <= S_HOLD;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      case ({w_push_term, w_pop_term})
        2'b10:   r_term_cnt <= r_term_cnt + LW'(1);
        2'b01:   r_term_cnt <= r_term_cnt - LW'(1);
        default: r_term_cnt <= r_term_cnt;
      endcase
    end
  end

  // Pass-through builds never leave HOLD, so the state output stays quiet there.
  always_comb begin
    w_state_nxt = r_state;
    if (LINE_MODE != 0) begin
      case (r_state)
        S_HOLD: begin
          if (r_term_cnt != '0)                     w_state_nxt = S_RELEASE;
          else if ((r_level == FULL) || flush_i)    w_state_nxt = S_FLUSH;
        end
        S_RELEASE: begin
          // Leave only when the last buffered terminator is the byte being popped.
          if (w_pop_term && (r_term_cnt == LW'(1)) && !w_push_term)
            w_state_nxt = S_HOLD;
        end
        S_FLUSH: begin
          if (r_level == '0) w_state_nxt = S_HOLD;
        end
        default: w_state_nxt = S_HOLD;
      endcase
    end
  end

endmodule
